nrf2401_spi_ctrl: RTL



---
 rtl/nrf2401_pkg.sv | 24 ++
 rtl/nrf2401_clk_div.sv | 22 ++
 rtl/nrf2401_spi_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nrf2401_pkg.sv
// Shared definitions for the nRF2401 3-wire controller: register map,
// CTRL/STATUS bit positions and the serial sequencer states.
package nrf2401_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_CE  = 0;
  localparam int CTRL_CS  = 1;
  localparam int CTRL_RX  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DR1  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/nrf2401_clk_div.sv
// Phase timer for CLK1: one-cycle tick every CLK_DIV cycles while enabled,
// held at zero while disabled so every transfer starts on a fresh phase.
module nrf2401_clk_div #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt_q;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !en) cnt_q <= '0;
    else if (tick)    cnt_q <= '0;
    else              cnt_q <= cnt_q + 8'd1;
  end

endmodule

// File: rtl/nrf2401_spi_ctrl.sv
// Avalon-MM slave that shifts one byte at a time over the nRF2401 3-wire
// interface (MSB first) and exposes CE/CS and busy/done/DR1 as registers.
module nrf2401_spi_ctrl
  import nrf2401_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       nrf_ce,
  output logic       nrf_cs,
  output logic       nrf_clk1,
  output logic       nrf_data_out,
  output logic       nrf_data_oe,
  input  logic       nrf_data_in,
  input  logic       nrf_dr1
);

  state_e     state_q, state_d;
  logic [7:0] txdata_q, rxdata_q, shreg_q;
  logic [2:0] ctrl_q;
  logic [2:0] bit_cnt_q;
  logic       done_q, rx_lat_q;
  logic [1:0] din_pipe, dr1_pipe;
  logic       tick, busy, wr, start, shift_en, fin;
  logic [7:0] shifted;

  assign wr       = chipselect & ~write_n;
  assign busy     = (state_q != S_IDLE);
  assign start    = wr && (address == ADDR_TXDATA) && !busy;
  assign shift_en = (state_q == S_HIGH) && tick;
  assign shifted  = {shreg_q[6:0], din_pipe[1]};

  nrf2401_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOW;
      S_LOW:  if (tick)  state_d = S_HIGH;
      S_HIGH: if (tick) begin
        if (bit_cnt_q == 3'd0) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end else begin
          state_d = S_LOW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txdata_q  <= '0;
      rxdata_q  <= '0;
      shreg_q   <= '0;
      ctrl_q    <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      rx_lat_q  <= 1'b0;
      din_pipe  <= '0;
      dr1_pipe  <= '0;
    end else begin
      din_pipe <= {din_pipe[0], nrf_data_in};
      dr1_pipe <= {dr1_pipe[0], nrf_dr1};

      if (start) begin
        txdata_q  <= writedata;
        shreg_q   <= writedata;
        bit_cnt_q <= 3'd7;
        rx_lat_q  <= ctrl_q[CTRL_RX];
      end else if (shift_en) begin
        shreg_q <= shifted;
        if (bit_cnt_q != 3'd0) bit_cnt_q <= bit_cnt_q - 3'd1;
      end

      if (fin) rxdata_q <= shifted;

      if (wr && (address == ADDR_CTRL)) ctrl_q <= writedata[2:0];

      // Completion beats a concurrent STATUS write so no done event is lost.
      if (fin)                                done_q <= 1'b1;
      else if (wr && (address == ADDR_STATUS)) done_q <= 1'b0;
    end
  end

  assign nrf_ce       = ctrl_q[CTRL_CE];
  assign nrf_cs       = ctrl_q[CTRL_CS];
  assign nrf_clk1     = (state_q == S_HIGH);
  assign nrf_data_out = busy & shreg_q[7];
  // Pad is released while idle; direction follows the mode latched at start.
  assign nrf_data_oe  = busy & ~rx_lat_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_TXDATA: readdata = txdata_q;
      ADDR_RXDATA: readdata = rxdata_q;
      ADDR_CTRL:   readdata = {5'b0, ctrl_q};
      ADDR_STATUS: readdata = {5'b0, dr1_pipe[1], done_q, busy};
      default:     readdata = '0;
    endcase
  end

endmodule
